edge_detector_multi: RTL and testbench

- Multi-channel debounced edge detector. Successor to the single-channel rising-edge/noise-filter block.
- Each channel synchronises an asynchronous input, tracks a debounced level, and emits one-cycle rising and/or falling pulses according to a runtime mode.
- After every accepted edge, the channel applies a configurable lockout (hold) time.
- Sits between board inputs (buttons/switches) and control FSMs.

---
 rtl/edge_detector_multi_if.sv | 37 +++
 rtl/edge_detector_multi.sv | 161 ++++++++++++++++
 tb/tb_edge_detector_multi.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/edge_detector_multi_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// edge_detector_multi_if
//   Signal bundle between board-level inputs and the multi-channel debounced
//   edge detector.
//
//   din        raw asynchronous inputs, one bit per channel
//   mode       pulse enable: 00 rising, 01 falling, 10 both, 11 none
//   rising     one-cycle pulse per channel on an accepted rising edge
//   falling    one-cycle pulse per channel on an accepted falling edge
//   level      debounced level per channel
//   any_event  OR of all rising and falling bits
//
//   master: the side that drives din/mode (board/bench)
//   slave : the detector itself
//   CHANNELS must match the CHANNELS parameter of the attached detector.
// -----------------------------------------------------------------------------
interface edge_detector_multi_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] din;
    logic [1:0]          mode;
    logic [CHANNELS-1:0] rising;
    logic [CHANNELS-1:0] falling;
    logic [CHANNELS-1:0] level;
    logic                any_event;

    modport master (
        output din, mode,
        input  rising, falling, level, any_event
    );

    modport slave (
        input  din, mode,
        output rising, falling, level, any_event
    );
endinterface

// File: rtl/edge_detector_multi.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// edge_detector_multi
//   Multi-channel debounced edge detector. Each channel synchronises its raw
//   input, tracks a debounced level and emits one-cycle rising/falling pulses
//   gated by mode. After every accepted edge the channel ignores its input for
//   exactly HOLD_CYCLES clock edges.
//
//   Ports:
//     clock  system clock, all logic on the rising edge
//     reset  asynchronous active-low reset (0 = reset)
//     bus    edge_detector_multi_if.slave (din, mode in; rising, falling,
//            level, any_event out)
//
//   Parameters:
//     CHANNELS     number of independent channels (>=1)
//     HOLD_CYCLES  lockout length in clock cycles after each edge (>=1)
//     SYNC_STAGES  synchroniser depth per channel (>=2)
// -----------------------------------------------------------------------------
module edge_detector_multi #(
    parameter int CHANNELS    = 4,
    parameter int HOLD_CYCLES = 130000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clock,
    input  logic                reset,
    edge_detector_multi_if.slave bus
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOW,
        ST_RISE_WAIT,
        ST_HIGH,
        ST_FALL_WAIT
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers: sync_q[0] faces the pins, the last stage feeds
    // the channel FSMs.
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] s;

    // NOTE: the synchroniser chain is a small register array, not a RAM, so
    // every stage is reset; this guarantees a fresh edge after reset release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= bus.din;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Per-channel FSM: state/counter/level are independent of mode; mode
    // only gates the pulse registers.
    // ------------------------------------------------------------------
    state_t              state_q [CHANNELS];
    state_t              state_d [CHANNELS];
    logic [CNT_W-1:0]    cnt_q   [CHANNELS];
    logic [CNT_W-1:0]    cnt_d   [CHANNELS];
    logic [CHANNELS-1:0] level_q, level_d;
    logic [CHANNELS-1:0] rise_q,  rise_d;
    logic [CHANNELS-1:0] fall_q,  fall_d;

    logic rise_en;
    logic fall_en;

    assign rise_en = (bus.mode == 2'b00) || (bus.mode == 2'b10);
    assign fall_en = (bus.mode == 2'b01) || (bus.mode == 2'b10);

    // NOTE: combinational logic uses blocking assignments, and every output
    // gets its default first so no path through the case can infer a latch.
    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];

            case (state_q[i])
                ST_LOW: begin
                    if (s[i]) begin
                        state_d[i] = ST_RISE_WAIT;
                        level_d[i] = 1'b1;
                        cnt_d[i]   = '0;
                        rise_d[i]  = rise_en;
                    end
                end
                ST_RISE_WAIT: begin
                    // NOTE: terminal compare comes before the increment, so
                    // the counter stops at HOLD_CYCLES-1 and can never wrap.
                    if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = ST_HIGH;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (!s[i]) begin
                        state_d[i] = ST_FALL_WAIT;
                        level_d[i] = 1'b0;
                        cnt_d[i]   = '0;
                        fall_d[i]  = fall_en;
                    end
                end
                ST_FALL_WAIT: begin
                    if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = ST_LOW;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = ST_LOW;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values computed from the previous cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= ST_LOW;
                cnt_q[i]   <= '0;
            end
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign bus.rising    = rise_q;
    assign bus.falling   = fall_q;
    assign bus.level     = level_q;
    // Combinational OR of registered pulses: same cycle as the pulses.
    assign bus.any_event = |{rise_q, fall_q};

endmodule

// File: tb/tb_edge_detector_multi.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_edge_detector_multi
//   Self-checking bench for edge_detector_multi (CHANNELS=4, HOLD_CYCLES=8,
//   SYNC_STAGES=2). A behavioural model (delay queue + per-channel "locked
//   until" cycle) is compared against the DUT after every clock edge, and a
//   set of directed scenarios pins the model with literal expectations.
// -----------------------------------------------------------------------------
module tb_edge_detector_multi;

    localparam int CH   = 4;
    localparam int HOLD = 8;
    localparam int SYNC = 2;

    logic clock;
    logic reset;

    edge_detector_multi_if #(.CHANNELS(CH)) bus ();

    edge_detector_multi #(
        .CHANNELS   (CH),
        .HOLD_CYCLES(HOLD),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: the FSM sees din delayed by SYNC edges; a channel
    // accepts an edge whenever it is unlocked and the delayed input differs
    // from its level, then stays locked for HOLD further edges.
    // ------------------------------------------------------------------
    logic [CH-1:0] hist [$];
    logic [CH-1:0] m_level, m_rise, m_fall;
    longint        m_unlock [CH];
    longint        m_cyc;

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < SYNC; k++) hist.push_back('0);
        m_level = '0;
        m_rise  = '0;
        m_fall  = '0;
        m_cyc   = 0;
        for (int i = 0; i < CH; i++) m_unlock[i] = 0;
    endtask

    task automatic model_step(input logic [CH-1:0] d, input logic [1:0] md);
        logic [CH-1:0] seen;
        seen = hist.pop_front();
        hist.push_back(d);
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < CH; i++) begin
            if (m_cyc >= m_unlock[i] && seen[i] != m_level[i]) begin
                m_level[i]  = seen[i];
                m_unlock[i] = m_cyc + HOLD + 1;
                if (seen[i]) m_rise[i] = (md == 2'b00 || md == 2'b10);
                else         m_fall[i] = (md == 2'b01 || md == 2'b10);
            end
        end
        m_cyc++;
    endtask

    initial model_reset();

    // Single compare process: step the model on each edge, check 1 ns later.
    always @(posedge clock) begin
        if (!reset) model_reset();
        else        model_step(bus.din, bus.mode);
        #1;
        check("cyc_rising",  bus.rising,    m_rise);
        check("cyc_falling", bus.falling,   m_fall);
        check("cyc_level",   bus.level,     m_level);
        check("cyc_any",     bus.any_event, |{m_rise, m_fall});
    end

    // Watchdog: the run is fixed-length, this only guards a broken build.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Directed scenarios followed by randomized traffic.
    // ------------------------------------------------------------------
    initial begin : main
        logic [1:0] modes  [3];
        int         exp_nr [3];
        int         exp_nf [3];
        int         nr, nf, nany;
        logic [CH-1:0] acc;

        modes  = '{2'b00, 2'b01, 2'b11};
        exp_nr = '{1, 0, 0};
        exp_nf = '{0, 1, 0};

        // Reset / idle
        bus.din  = 4'hF;
        bus.mode = 2'b10;
        reset    = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_rising",  bus.rising,    0);
        check("reset_falling", bus.falling,   0);
        check("reset_level",   bus.level,     0);
        check("reset_any",     bus.any_event, 0);
        bus.din = 4'h0;
        reset   = 1'b1;
        repeat (20) @(negedge clock);
        check("idle_level", bus.level, 0);

        // Basic rise: set before edge k, visible after edge k+2
        bus.din = 4'b0001;
        repeat (2) @(negedge clock);
        check("rise_early", bus.rising, 0);
        @(negedge clock);
        check("rise_pulse", bus.rising,    4'b0001);
        check("rise_any",   bus.any_event, 1);
        check("rise_level", bus.level,     4'b0001);

        // Bounce during lockout, settle low: falling 9 edges after the rise
        for (int i = 0; i < 6; i++) begin
            bus.din[0] = ~bus.din[0];
            @(negedge clock);
            check("bounce_quiet", {bus.any_event, bus.rising, bus.falling}, 0);
        end
        bus.din[0] = 1'b0;
        repeat (2) begin
            @(negedge clock);
            check("bounce_quiet", {bus.any_event, bus.rising, bus.falling}, 0);
        end
        @(negedge clock);
        check("bounce_fall", bus.falling, 4'b0001);
        repeat (12) @(negedge clock);

        // Mode gating
        for (int m = 0; m < 3; m++) begin
            bus.mode = modes[m];
            bus.din  = 4'b0001;
            nr = 0;
            nf = 0;
            repeat (14) begin
                @(negedge clock);
                nr += int'(bus.rising[0]);
                nf += int'(bus.falling[0]);
            end
            check("mode_level_hi", bus.level[0], 1);
            bus.din = 4'b0000;
            repeat (14) begin
                @(negedge clock);
                nr += int'(bus.rising[0]);
                nf += int'(bus.falling[0]);
            end
            check("mode_level_lo", bus.level[0], 0);
            check("mode_rise_cnt", nr, exp_nr[m]);
            check("mode_fall_cnt", nf, exp_nf[m]);
        end
        bus.mode = 2'b10;

        // Simultaneous edges on all channels
        bus.din = 4'hF;
        nany = 0;
        acc  = '0;
        repeat (14) begin
            @(negedge clock);
            if (bus.any_event) nany++;
            acc |= bus.rising;
        end
        check("simul_rise", acc,  4'hF);
        check("simul_any",  nany, 1);
        bus.din = 4'h5;
        nany = 0;
        acc  = '0;
        repeat (14) begin
            @(negedge clock);
            if (bus.any_event) nany++;
            acc |= bus.falling;
        end
        check("simul_fall",     acc,  4'hA);
        check("simul_fall_any", nany, 1);
        bus.din = 4'h0;
        repeat (14) @(negedge clock);

        // Reset during RISE_WAIT with din[2] high
        bus.din = 4'b0100;
        repeat (3) @(negedge clock);
        check("hold_rise", bus.rising, 4'b0100);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("midrst_rising",  bus.rising,    0);
        check("midrst_falling", bus.falling,   0);
        check("midrst_level",   bus.level,     0);
        check("midrst_any",     bus.any_event, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) begin
            @(negedge clock);
            check("rel_quiet", bus.rising, 0);
        end
        @(negedge clock);
        check("rel_rise", bus.rising, 4'b0100);
        bus.din = 4'b0000;
        repeat (8) begin
            @(negedge clock);
            check("rel_lockout", bus.falling, 0);
        end
        @(negedge clock);
        check("rel_fall", bus.falling, 4'b0100);

        // Randomized traffic: bursty/calm phases, mode changes, rare resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            if (!reset) begin
                if ($urandom_range(0, 2) == 0) reset = 1'b1;
            end else if ($urandom_range(0, 499) == 0) begin
                reset = 1'b0;
            end
            if (((c / 100) % 2) == 0) begin
                if ($urandom_range(0, 2) == 0) bus.din = CH'($urandom);
            end else begin
                if ($urandom_range(0, 24) == 0) bus.din = CH'($urandom);
            end
            if ($urandom_range(0, 19) == 0) bus.mode = 2'($urandom);
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (20) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
